nanorv32_div_ctrl: RTL and testbench
====================================

NANORV32_DIV_CTRL -- requirements
Module: nanorv32_div_ctrl

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Parameter: FAST_SPECIAL, 1, enables local resolution of divide-by-zero and signed overflow without issuing to the divider.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 op_valid  input  1  pipeline presents a divide/remainder operation.
REQ-006 op_sel  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 op_a  input  32  dividend.
REQ-008 op_b  input  32  divisor.
REQ-009 op_ready  output  1  controller accepts the operation this cycle.
REQ-010 res_valid  output  1  res_data holds a completed result.
REQ-011 res_data  output  32  quotient or remainder.
REQ-012 res_ready  input  1  pipeline consumes the result.
REQ-013 flush  input  1  abandon any in-flight operation.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 div_req_valid  output  1  request to the shared divider.
REQ-016 div_req_ready  input  1  divider accepts the request.
REQ-017 div_req_signed  output  1  signed operation (DIV/REM).
REQ-018 div_req_rem  output  1  remainder requested (REM/REMU).
REQ-019 div_req_a / div_req_b  output  32 each  latched operands.
REQ-020 div_resp_valid  input  1  one-cycle pulse: divider result available.
REQ-021 div_resp_result  input  32  divider result, valid with div_resp_valid.

Function
REQ-022 The FSM SHALL have states IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-023 op_ready SHALL be 1 only in IDLE with flush=0; acceptance = op_valid & op_ready.
REQ-024 On acceptance, op_sel, op_a and op_b SHALL be latched; div_req_* outputs SHALL be driven from the latched values only.
REQ-025 Special cases (FAST_SPECIAL=1): op_b==0 -> DIV/DIVU 0xFFFFFFFF, REM/REMU op_a; signed op with op_a==0x80000000 and op_b==0xFFFFFFFF -> DIV 0x80000000, REM 0; the result SHALL be loaded and the FSM SHALL go IDLE->DONE (res_valid on the cycle after acceptance), with no div_req_valid.
REQ-026 Otherwise IDLE->ISSUE; div_req_valid=1 throughout ISSUE, held stable until div_req_ready; ISSUE->WAIT on div_req_valid & div_req_ready.
REQ-027 In WAIT, on div_resp_valid, div_resp_result SHALL be registered into res_data and the FSM SHALL go WAIT->DONE (res_valid on the next cycle).
REQ-028 In DONE, res_valid=1 and res_data SHALL be stable; DONE->IDLE on res_ready; new acceptance is possible no earlier than the following cycle.
REQ-029 flush SHALL take priority over all other events: ISSUE->IDLE (no handshake that cycle, div_req_valid=0); WAIT->DRAIN, or WAIT->IDLE if div_resp_valid is in the same cycle (result discarded); DONE->IDLE (result dropped); IDLE: no acceptance.
REQ-030 DRAIN SHALL wait for div_resp_valid, discard the result, and then go to IDLE; op_ready=0 and div_req_valid=0 in DRAIN.
REQ-031 div_resp_valid outside WAIT/DRAIN SHALL be ignored.
REQ-032 res_valid SHALL be asserted for exactly one transaction per accepted, unflushed operation.

Reset
REQ-033 With rst=1 at a clock edge: state IDLE; res_valid=0, res_data=0, div_req_valid=0, div_req_signed=0, div_req_rem=0, div_req_a=div_req_b=0, busy=0; op_ready=0 while rst=1.
REQ-034 Reset mid-operation SHALL abandon the operation with no res_valid; the divider shares rst.

Verification
REQ-035 DIV 20 / 0xFFFFFFFD, divider responds 0xFFFFFFFA after 10 cycles -> one div_req handshake with signed=1, rem=0; res_data 0xFFFFFFFA, res_valid on the cycle after div_resp_valid.
REQ-036 DIVU 0x1234 / 0 -> res_valid on the cycle after acceptance, res_data 0xFFFFFFFF, div_req_valid never asserted; REMU 0x1234 / 0 -> 0x1234.
REQ-037 REM 0x80000000 % 0xFFFFFFFF -> res_data 0, fast path; DIV of the same operands -> 0x80000000.
REQ-038 flush in WAIT, div_resp_valid 3 cycles later with 0xDEAD -> no res_valid, busy until the response, then IDLE; next DIVU 100/7 yields 14.
REQ-039 res_ready held low 5 cycles in DONE -> res_valid and res_data stable, op_ready=0; consumed on the 6th cycle.
REQ-040 div_req_ready low 4 cycles in ISSUE -> div_req_valid/a/b stable; rst in ISSUE -> IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/nanorv32_div_ctrl_if.sv
// Handshake bundle between the pipeline, the divide controller and the shared divider.
// slave is the controller's view; master is the pipeline/divider side.
interface nanorv32_div_ctrl_if #(
    parameter int unsigned DATA_W = 32
);
    logic              op_valid;
    logic [1:0]        op_sel;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              op_ready;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              flush;
    logic              busy;
    logic              div_req_valid;
    logic              div_req_ready;
    logic              div_req_signed;
    logic              div_req_rem;
    logic [DATA_W-1:0] div_req_a;
    logic [DATA_W-1:0] div_req_b;
    logic              div_resp_valid;
    logic [DATA_W-1:0] div_resp_result;

    modport slave (
        input  op_valid, op_sel, op_a, op_b, res_ready, flush,
               div_req_ready, div_resp_valid, div_resp_result,
        output op_ready, res_valid, res_data, busy,
               div_req_valid, div_req_signed, div_req_rem, div_req_a, div_req_b
    );

    modport master (
        output op_valid, op_sel, op_a, op_b, res_ready, flush,
               div_req_ready, div_resp_valid, div_resp_result,
        input  op_ready, res_valid, res_data, busy,
               div_req_valid, div_req_signed, div_req_rem, div_req_a, div_req_b
    );
endinterface

// File: rtl/nanorv32_div_ctrl.sv
// Divide/remainder controller: accepts one op, resolves special cases locally or issues it
// to the shared divider, and returns the result to the pipeline with flush support.
module nanorv32_div_ctrl #(
    parameter int unsigned DATA_W       = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input logic              clk,
    input logic              rst,
    nanorv32_div_ctrl_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StDrain} state_e;

    localparam logic [DATA_W-1:0] MinNeg = {1'b1, {(DATA_W-1){1'b0}}};

    state_e            state_q, state_d;
    logic              signed_q, signed_d;
    logic              rem_q, rem_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] res_q, res_d;

    logic              accept;
    logic              op_signed;
    logic              op_rem;
    logic              div_zero;
    logic              ovf;
    logic              special;
    logic [DATA_W-1:0] special_res;

    // RISC-V defined results for divide-by-zero and signed overflow.
    always_comb begin
        op_signed = ~bus.op_sel[0];
        op_rem    = bus.op_sel[1];
        div_zero  = (bus.op_b == '0);
        ovf       = op_signed && (bus.op_a == MinNeg) && (bus.op_b == '1);
        special   = FAST_SPECIAL && (div_zero || ovf);
        if (div_zero) begin
            special_res = op_rem ? bus.op_a : '1;
        end else begin
            special_res = op_rem ? '0 : MinNeg;
        end
    end

    assign bus.op_ready       = (state_q == StIdle) && !bus.flush && !rst;
    assign accept             = bus.op_valid && bus.op_ready;
    assign bus.busy           = (state_q != StIdle);
    assign bus.res_valid      = (state_q == StDone);
    assign bus.res_data       = res_q;
    assign bus.div_req_valid  = (state_q == StIssue) && !bus.flush;
    assign bus.div_req_signed = signed_q;
    assign bus.div_req_rem    = rem_q;
    assign bus.div_req_a      = a_q;
    assign bus.div_req_b      = b_q;

    always_comb begin
        state_d  = state_q;
        signed_d = signed_q;
        rem_d    = rem_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    signed_d = op_signed;
                    rem_d    = op_rem;
                    a_d      = bus.op_a;
                    b_d      = bus.op_b;
                    if (special) begin
                        res_d   = special_res;
                        state_d = StDone;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else if (bus.div_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A response coinciding with flush already retires the divider's op.
                if (bus.flush) begin
                    state_d = bus.div_resp_valid ? StIdle : StDrain;
                end else if (bus.div_resp_valid) begin
                    res_d   = bus.div_resp_result;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.flush || bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (bus.div_resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            signed_q <= 1'b0;
            rem_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            signed_q <= signed_d;
            rem_q    <= rem_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_nanorv32_div_ctrl.sv
// Directed bench for nanorv32_div_ctrl; the bench plays both the pipeline and the divider.
module tb_nanorv32_div_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    nanorv32_div_ctrl_if #(.DATA_W(32)) bus ();

    nanorv32_div_ctrl #(
        .DATA_W      (32),
        .FAST_SPECIAL(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_err   = 0;
    int hs_cnt  = 0;
    int req_cnt = 0;
    int hs_mark;
    int req_mark;

    always @(posedge clk) begin
        if (!rst && bus.div_req_valid && bus.div_req_ready) hs_cnt++;
        if (!rst && bus.div_req_valid) req_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 2-3 time units after each rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.op_valid = 1'b1;
        bus.op_sel   = sel;
        bus.op_a     = a;
        bus.op_b     = b;
        #1;
        chk("op_ready_idle", bus.op_ready, 32'd1);
        cyc();
        bus.op_valid = 1'b0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        #1;
    endtask

    task automatic fast(input string tag, input logic [1:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
        req_mark = req_cnt;
        issue(sel, a, b);
        chk({tag, "_valid"}, bus.res_valid, 32'd1);
        chk({tag, "_data"}, bus.res_data, exp);
        chk({tag, "_op_ready"}, bus.op_ready, 32'd0);
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
        #1;
        chk({tag, "_consumed"}, bus.res_valid, 32'd0);
        chk({tag, "_no_req"}, req_cnt, req_mark);
    endtask

    task automatic slow(input string tag, input logic [1:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic sgn, input logic rem,
                        input int lat, input logic [31:0] resp);
        hs_mark = hs_cnt;
        bus.div_req_ready = 1'b1;
        issue(sel, a, b);
        chk({tag, "_req_valid"}, bus.div_req_valid, 32'd1);
        chk({tag, "_signed"}, bus.div_req_signed, 32'(sgn));
        chk({tag, "_rem"}, bus.div_req_rem, 32'(rem));
        chk({tag, "_req_a"}, bus.div_req_a, a);
        chk({tag, "_req_b"}, bus.div_req_b, b);
        cyc();
        bus.div_req_ready = 1'b0;
        #1;
        chk({tag, "_wait_no_req"}, bus.div_req_valid, 32'd0);
        repeat (lat - 1) cyc();
        chk({tag, "_wait_no_res"}, bus.res_valid, 32'd0);
        bus.div_resp_valid  = 1'b1;
        bus.div_resp_result = resp;
        cyc();
        bus.div_resp_valid  = 1'b0;
        bus.div_resp_result = '0;
        #1;
        chk({tag, "_res_valid"}, bus.res_valid, 32'd1);
        chk({tag, "_res_data"}, bus.res_data, resp);
        chk({tag, "_one_hs"}, hs_cnt, hs_mark + 1);
        bus.res_ready = 1'b1;
        cyc();
        bus.res_ready = 1'b0;
        #1;
        chk({tag, "_idle"}, bus.busy, 32'd0);
    endtask

    initial begin
        bus.op_valid        = 1'b1;
        bus.op_sel          = 2'b00;
        bus.op_a            = 32'd1;
        bus.op_b            = 32'd1;
        bus.res_ready       = 1'b0;
        bus.flush           = 1'b0;
        bus.div_req_ready   = 1'b0;
        bus.div_resp_valid  = 1'b0;
        bus.div_resp_result = '0;

        // Reset values, op_ready held low while rst is high.
        cyc();
        cyc();
        #1;
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_res_valid", bus.res_valid, 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);
        chk("rst_req_valid", bus.div_req_valid, 32'd0);
        chk("rst_signed", bus.div_req_signed, 32'd0);
        chk("rst_rem", bus.div_req_rem, 32'd0);
        chk("rst_req_a", bus.div_req_a, 32'd0);
        chk("rst_req_b", bus.div_req_b, 32'd0);
        chk("rst_op_ready", bus.op_ready, 32'd0);
        bus.op_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_op_ready", bus.op_ready, 32'd1);

        slow("div_neg", 2'b00, 32'd20, 32'hFFFF_FFFD, 1'b1, 1'b0, 10, 32'hFFFF_FFFA);

        // Stray divider response in IDLE is ignored.
        bus.div_resp_valid  = 1'b1;
        bus.div_resp_result = 32'h0000_1234;
        cyc();
        bus.div_resp_valid = 1'b0;
        #1;
        chk("stray_resp_valid", bus.res_valid, 32'd0);
        chk("stray_resp_busy", bus.busy, 32'd0);

        fast("divu_zero", 2'b01, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF);
        fast("remu_zero", 2'b11, 32'h0000_1234, 32'd0, 32'h0000_1234);
        fast("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        fast("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        fast("div_zero", 2'b00, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFFF);

        // Flush in WAIT, divider answers 3 cycles later.
        bus.div_req_ready = 1'b1;
        issue(2'b01, 32'd5, 32'd1);
        cyc();
        bus.div_req_ready = 1'b0;
        bus.flush = 1'b1;
        #1;
        chk("flush_wait_op_ready", bus.op_ready, 32'd0);
        cyc();
        bus.flush = 1'b0;
        #1;
        chk("drain_busy", bus.busy, 32'd1);
        chk("drain_res_valid", bus.res_valid, 32'd0);
        chk("drain_req_valid", bus.div_req_valid, 32'd0);
        chk("drain_op_ready", bus.op_ready, 32'd0);
        cyc();
        chk("drain_busy2", bus.busy, 32'd1);
        cyc();
        bus.div_resp_valid  = 1'b1;
        bus.div_resp_result = 32'h0000_DEAD;
        cyc();
        bus.div_resp_valid = 1'b0;
        #1;
        chk("drained_busy", bus.busy, 32'd0);
        chk("drained_res_valid", bus.res_valid, 32'd0);
        chk("drained_op_ready", bus.op_ready, 32'd1);

        slow("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0, 1'b0, 3, 32'd14);

        // Backpressure in DONE: result held for 5 cycles with an op waiting.
        issue(2'b01, 32'd9, 32'd0);
        bus.op_valid = 1'b1;
        bus.op_a     = 32'd3;
        bus.op_b     = 32'd3;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_res_valid", bus.res_valid, 32'd1);
            chk("hold_res_data", bus.res_data, 32'hFFFF_FFFF);
            chk("hold_op_ready", bus.op_ready, 32'd0);
            cyc();
        end
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b1;
        #1;
        chk("hold_6th_valid", bus.res_valid, 32'd1);
        cyc();
        bus.res_ready = 1'b0;
        #1;
        chk("hold_consumed", bus.res_valid, 32'd0);
        chk("hold_idle", bus.busy, 32'd0);

        // Flush in DONE drops the result.
        issue(2'b11, 32'd7, 32'd0);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        #1;
        chk("flush_done_valid", bus.res_valid, 32'd0);
        chk("flush_done_busy", bus.busy, 32'd0);

        // Flush in ISSUE suppresses the request handshake.
        hs_mark = hs_cnt;
        issue(2'b00, 32'd3, 32'd2);
        bus.flush = 1'b1;
        bus.div_req_ready = 1'b1;
        #1;
        chk("flush_issue_req", bus.div_req_valid, 32'd0);
        cyc();
        bus.flush = 1'b0;
        bus.div_req_ready = 1'b0;
        #1;
        chk("flush_issue_busy", bus.busy, 32'd0);
        chk("flush_issue_no_hs", hs_cnt, hs_mark);

        // Request held stable under div_req_ready low, then reset in ISSUE.
        issue(2'b00, 32'd77, 32'd5);
        for (int i = 0; i < 4; i++) begin
            chk("stall_req_valid", bus.div_req_valid, 32'd1);
            chk("stall_req_a", bus.div_req_a, 32'd77);
            chk("stall_req_b", bus.div_req_b, 32'd5);
            cyc();
        end
        rst = 1'b1;
        cyc();
        #1;
        chk("rst_issue_busy", bus.busy, 32'd0);
        chk("rst_issue_req", bus.div_req_valid, 32'd0);
        chk("rst_issue_signed", bus.div_req_signed, 32'd0);
        chk("rst_issue_a", bus.div_req_a, 32'd0);
        chk("rst_issue_b", bus.div_req_b, 32'd0);
        chk("rst_issue_res", bus.res_valid, 32'd0);
        chk("rst_issue_op_ready", bus.op_ready, 32'd0);
        rst = 1'b0;
        cyc();
        chk("final_op_ready", bus.op_ready, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
